// File: rtl/rvv_fifo4_drain_skid.sv
// Drain stage for the 4-entry FIFO: turns pop/empty/head into a registered valid/ready
// stream through a two-entry (main + skid) buffer, with no combinational ready->pop path.
module rvv_fifo4_drain_skid #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_pop,
    input  logic              flush,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DWIDTH-1:0] main_data;
    logic [DWIDTH-1:0] skid_data;
    logic              accept;

    // Pop depends only on flopped state and upstream flags, never on out_ready.
    assign fifo_pop  = !fifo_empty && (state != FULL) && !flush && !rst;
    assign out_valid = (state != EMPTY) && !flush;
    assign accept    = out_valid && out_ready;
    assign out_data  = main_data;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            HALF:    occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // main always holds the oldest entry; skid only fills when main is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (fifo_pop) begin
                        main_data <= fifo_data;
                        state     <= HALF;
                    end
                end
                HALF: begin
                    if (fifo_pop && accept) begin
                        main_data <= fifo_data;
                    end else if (fifo_pop) begin
                        skid_data <= fifo_data;
                        state     <= FULL;
                    end else if (accept) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (accept) begin
                        main_data <= skid_data;
                        state     <= HALF;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_rvv_fifo4_drain_skid.sv
// Bench for rvv_fifo4_drain_skid: vector table for the directed scenarios, then random
// traffic against a queue-based model of the upstream FIFO and the two-entry buffer.
module tb_rvv_fifo4_drain_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fifo_data = 32'h1234_5678;
    logic        fifo_empty = 1'b0;
    logic        fifo_pop;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b1;
    logic [1:0]  occupancy;

    rvv_fifo4_drain_skid #(.DWIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntotal = 0;

    logic [31:0] upq[$];   // upstream FIFO contents, head at index 0
    logic [31:0] bq[$];    // entries held by the drain stage, oldest first

    logic        obs_pop;
    logic        obs_vld;
    logic [31:0] obs_data;
    logic [1:0]  obs_occ;

    typedef struct {
        int          np;
        logic [31:0] base;
        logic        rdy;
        logic        fl;
        logic        pop;
        logic        vld;
        logic [31:0] data;
        logic [1:0]  occ;
    } vec_t;

    vec_t tbl[25];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endfunction

    task automatic drive_fifo();
        fifo_empty = (upq.size() == 0);
        fifo_data  = (upq.size() != 0) ? upq[0] : $urandom;
    endtask

    task automatic cycle(input logic rdy, input logic fl);
        logic        e_pop;
        logic        e_vld;
        logic        acc;
        logic [31:0] head;
        out_ready = rdy;
        flush     = fl;
        drive_fifo();
        @(negedge clk);
        e_pop = (upq.size() > 0) && (bq.size() < 2) && !fl;
        e_vld = (bq.size() > 0) && !fl;
        chk("model_pop", 32'(fifo_pop), 32'(e_pop));
        chk("model_valid", 32'(out_valid), 32'(e_vld));
        if (e_vld) chk("model_data", out_data, bq[0]);
        chk("model_occ", 32'(occupancy), 32'(bq.size()));
        obs_pop  = fifo_pop;
        obs_vld  = out_valid;
        obs_data = out_data;
        obs_occ  = occupancy;
        acc  = e_vld && rdy;
        head = e_pop ? upq[0] : 32'h0;
        @(posedge clk);
        #1;
        if (fl) begin
            bq.delete();
        end else begin
            if (acc) void'(bq.pop_front());
            if (e_pop) bq.push_back(head);
        end
        if (e_pop) void'(upq.pop_front());
        drive_fifo();
    endtask

    initial begin
        // np, base, rdy, fl | pop, vld, data, occ
        tbl[0]  = '{4, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   2'd0};
        tbl[1]  = '{0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 2'd1};
        tbl[2]  = '{0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h101, 2'd1};
        tbl[3]  = '{0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 2'd1};
        tbl[4]  = '{0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h103, 2'd1};
        tbl[5]  = '{0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   2'd0};
        tbl[6]  = '{3, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   2'd0};
        tbl[7]  = '{0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 2'd1};
        tbl[8]  = '{0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 2'd2};
        tbl[9]  = '{0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 2'd2};
        tbl[10] = '{0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 2'd2};
        tbl[11] = '{0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h201, 2'd1};
        tbl[12] = '{0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h202, 2'd1};
        tbl[13] = '{0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   2'd0};
        tbl[14] = '{0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   2'd0};
        tbl[15] = '{0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   2'd0};
        tbl[16] = '{1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 2'd0};
        tbl[17] = '{0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 2'd1};
        tbl[18] = '{0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   2'd0};
        tbl[19] = '{3, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   2'd0};
        tbl[20] = '{0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 2'd1};
        tbl[21] = '{0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   2'd2};
        tbl[22] = '{0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   2'd0};
        tbl[23] = '{0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b1, 32'h302, 2'd1};
        tbl[24] = '{0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   2'd0};

        // Reset with a non-empty FIFO: nothing may be popped or presented.
        @(posedge clk);
        #2;
        chk("rst_pop", 32'(fifo_pop), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_occ", 32'(occupancy), 32'h0);
        chk("rst_data", out_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_fifo();

        for (int i = 0; i < 25; i++) begin
            for (int k = 0; k < tbl[i].np; k++) upq.push_back(tbl[i].base + 32'(k));
            cycle(tbl[i].rdy, tbl[i].fl);
            chk($sformatf("tbl%0d_pop", i), 32'(obs_pop), 32'(tbl[i].pop));
            chk($sformatf("tbl%0d_valid", i), 32'(obs_vld), 32'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("tbl%0d_data", i), obs_data, tbl[i].data);
            chk($sformatf("tbl%0d_occ", i), 32'(obs_occ), 32'(tbl[i].occ));
        end

        // Async reset while FULL: outputs drop before the next edge, stale entries vanish.
        for (int k = 0; k < 3; k++) upq.push_back(32'h400 + 32'(k));
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk("pre_rst_occ", 32'(occupancy), 32'h2);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_pop", 32'(fifo_pop), 32'h0);
        chk("arst_occ", 32'(occupancy), 32'h0);
        chk("arst_data", out_data, 32'h0);
        bq.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        cycle(1'b1, 1'b0);
        chk("post_rst_pop", 32'(obs_pop), 32'h1);
        cycle(1'b1, 1'b0);
        chk("post_rst_data", 32'(obs_vld) << 16 | (obs_data & 32'hFFFF), 32'h0001_0402);
        cycle(1'b1, 1'b0);

        for (int n = 0; n < 400; n++) begin
            if (upq.size() < 4 && $urandom_range(0, 1) == 1) upq.push_back($urandom);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
